// File: rtl/rvv_issue_ctrl.sv
// Issue/commit/retire controller between the scalar core's vector port and rvv_core.
// Tracks in-flight vector instructions in a circular buffer addressed by wrap-bit pointers.
module rvv_issue_ctrl #(
  parameter int unsigned IdWidth  = 3,
  parameter int unsigned CtxWidth = 32,
  parameter int unsigned XLEN     = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_insn_i,
  input  logic [CtxWidth-1:0] issue_ctx_i,
  output logic [IdWidth-1:0]  issue_id_o,
  output logic                core_valid_o,
  input  logic                core_ready_i,
  output logic [31:0]         core_insn_o,
  output logic [IdWidth-1:0]  core_id_o,
  output logic [CtxWidth-1:0] core_ctx_o,
  input  logic                commit_req_i,
  output logic                can_commit_o,
  output logic [IdWidth-1:0]  can_commit_id_o,
  input  logic                flush_i,
  output logic                flush_o,
  input  logic                core_done_i,
  input  logic [IdWidth-1:0]  core_done_id_i,
  input  logic                core_illegal_i,
  input  logic [XLEN-1:0]     core_result_i,
  output logic                retire_valid_o,
  output logic [IdWidth-1:0]  retire_id_o,
  output logic                retire_illegal_o,
  output logic [XLEN-1:0]     retire_result_o,
  output logic                protocol_err_o,
  output logic [IdWidth:0]    outstanding_o
);

  localparam int unsigned Depth = 2 ** IdWidth;

  typedef logic [IdWidth:0] ptr_t;

  ptr_t iss_ptr, cmt_ptr, ret_ptr;

  logic [Depth-1:0] done_q;
  logic [Depth-1:0] illegal_q;
  logic [XLEN-1:0]  result_q [Depth];

  logic               flush_q;
  logic               can_commit_q;
  logic [IdWidth-1:0] can_commit_id_q;
  logic               retire_valid_q;
  logic [IdWidth-1:0] retire_id_q;
  logic               retire_illegal_q;
  logic [XLEN-1:0]    retire_result_q;
  logic               protocol_err_q;

  ptr_t               occupancy;
  ptr_t               committed_cnt;
  ptr_t               cmt_next;
  logic               full;
  logic               flush_block;
  logic               issue_fire;
  logic               commit_ok;
  logic [IdWidth-1:0] iss_slot;
  logic [IdWidth-1:0] head;
  logic [IdWidth-1:0] done_off;
  logic               done_ok;
  logic               head_bypass;
  logic               retire_fire;
  logic               retire_illegal_d;
  logic [XLEN-1:0]    retire_result_d;

  // A slot being retired this cycle is still counted so it frees one cycle after the retire pulse.
  assign occupancy     = iss_ptr - ret_ptr + {{IdWidth{1'b0}}, retire_valid_q};
  assign full          = (occupancy == ptr_t'(Depth));
  assign flush_block   = flush_i || flush_q;
  assign iss_slot      = iss_ptr[IdWidth-1:0];
  assign head          = ret_ptr[IdWidth-1:0];

  assign issue_ready_o = core_ready_i && !full && !flush_block;
  assign core_valid_o  = issue_valid_i && !full && !flush_block;
  assign issue_fire    = issue_valid_i && issue_ready_o;
  assign issue_id_o    = iss_slot;
  assign core_id_o     = iss_slot;
  assign core_insn_o   = issue_insn_i;
  assign core_ctx_o    = issue_ctx_i;

  assign commit_ok     = commit_req_i && (cmt_ptr != iss_ptr);
  assign cmt_next      = cmt_ptr + {{IdWidth{1'b0}}, commit_ok};

  // Done is only legal for committed, not yet retired IDs: offset from head below committed count.
  assign committed_cnt = cmt_ptr - ret_ptr;
  assign done_off      = core_done_id_i - head;
  assign done_ok       = core_done_i && ({1'b0, done_off} < committed_cnt);
  assign head_bypass   = done_ok && (core_done_id_i == head);

  assign retire_fire      = (ret_ptr != cmt_ptr) && (done_q[head] || head_bypass);
  assign retire_illegal_d = head_bypass ? core_illegal_i : illegal_q[head];
  assign retire_result_d  = head_bypass ? core_result_i : result_q[head];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iss_ptr          <= '0;
      cmt_ptr          <= '0;
      ret_ptr          <= '0;
      done_q           <= '0;
      flush_q          <= 1'b0;
      can_commit_q     <= 1'b0;
      can_commit_id_q  <= '0;
      retire_valid_q   <= 1'b0;
      retire_id_q      <= '0;
      retire_illegal_q <= 1'b0;
      retire_result_q  <= '0;
      protocol_err_q   <= 1'b0;
    end else begin
      flush_q      <= flush_i;
      can_commit_q <= commit_ok;
      if (commit_ok) begin
        can_commit_id_q <= cmt_ptr[IdWidth-1:0];
      end
      cmt_ptr <= cmt_next;

      // Flush truncates to the commit pointer after this cycle's commit has been applied.
      if (flush_i) begin
        iss_ptr <= cmt_next;
      end else if (issue_fire) begin
        iss_ptr <= iss_ptr + ptr_t'(1);
      end

      if (issue_fire) begin
        done_q[iss_slot] <= 1'b0;
      end
      if (done_ok) begin
        done_q[core_done_id_i] <= 1'b1;
      end

      retire_valid_q <= retire_fire;
      if (retire_fire) begin
        ret_ptr          <= ret_ptr + ptr_t'(1);
        retire_id_q      <= head;
        retire_illegal_q <= retire_illegal_d;
        retire_result_q  <= retire_result_d;
      end

      if ((commit_req_i && !commit_ok) || (core_done_i && !done_ok)) begin
        protocol_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (done_ok) begin
      illegal_q[core_done_id_i] <= core_illegal_i;
      result_q[core_done_id_i]  <= core_result_i;
    end
  end

  assign flush_o          = flush_q;
  assign can_commit_o     = can_commit_q;
  assign can_commit_id_o  = can_commit_id_q;
  assign retire_valid_o   = retire_valid_q;
  assign retire_id_o      = retire_id_q;
  assign retire_illegal_o = retire_illegal_q;
  assign retire_result_o  = retire_result_q;
  assign protocol_err_o   = protocol_err_q;
  assign outstanding_o    = occupancy;

endmodule

// File: tb/tb_rvv_issue_ctrl.sv
// Self-checking bench for rvv_issue_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a sequence-number based model.
module tb_rvv_issue_ctrl;

  localparam int IdWidth  = 3;
  localparam int CtxWidth = 32;
  localparam int XLEN     = 64;
  localparam int Depth    = 8;
  localparam int MaxSeq   = 8192;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                issue_valid_i = 1'b0;
  logic                issue_ready_o;
  logic [31:0]         issue_insn_i = '0;
  logic [CtxWidth-1:0] issue_ctx_i = '0;
  logic [IdWidth-1:0]  issue_id_o;
  logic                core_valid_o;
  logic                core_ready_i = 1'b0;
  logic [31:0]         core_insn_o;
  logic [IdWidth-1:0]  core_id_o;
  logic [CtxWidth-1:0] core_ctx_o;
  logic                commit_req_i = 1'b0;
  logic                can_commit_o;
  logic [IdWidth-1:0]  can_commit_id_o;
  logic                flush_i = 1'b0;
  logic                flush_o;
  logic                core_done_i = 1'b0;
  logic [IdWidth-1:0]  core_done_id_i = '0;
  logic                core_illegal_i = 1'b0;
  logic [XLEN-1:0]     core_result_i = '0;
  logic                retire_valid_o;
  logic [IdWidth-1:0]  retire_id_o;
  logic                retire_illegal_o;
  logic [XLEN-1:0]     retire_result_o;
  logic                protocol_err_o;
  logic [IdWidth:0]    outstanding_o;

  always #5 clk_i = ~clk_i;

  rvv_issue_ctrl #(.IdWidth(IdWidth), .CtxWidth(CtxWidth), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_insn_i(issue_insn_i), .issue_ctx_i(issue_ctx_i), .issue_id_o(issue_id_o),
    .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
    .core_insn_o(core_insn_o), .core_id_o(core_id_o), .core_ctx_o(core_ctx_o),
    .commit_req_i(commit_req_i), .can_commit_o(can_commit_o), .can_commit_id_o(can_commit_id_o),
    .flush_i(flush_i), .flush_o(flush_o),
    .core_done_i(core_done_i), .core_done_id_i(core_done_id_i),
    .core_illegal_i(core_illegal_i), .core_result_i(core_result_i),
    .retire_valid_o(retire_valid_o), .retire_id_o(retire_id_o),
    .retire_illegal_o(retire_illegal_o), .retire_result_o(retire_result_o),
    .protocol_err_o(protocol_err_o), .outstanding_o(outstanding_o)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Model: instructions are numbered by issue order; IDs are sequence numbers modulo Depth.
  int          m_iss, m_cmt, m_ret;
  bit          m_flush_prev, m_flush_o, m_cc, m_rv, m_rill, m_err;
  int          m_cc_id, m_rid;
  logic [63:0] m_rres;
  bit          m_done [MaxSeq];
  bit          m_ill  [MaxSeq];
  logic [63:0] m_res  [MaxSeq];

  logic               last_ready;
  logic [IdWidth-1:0] last_id;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_iss = 0; m_cmt = 0; m_ret = 0;
    m_flush_prev = 0; m_flush_o = 0; m_cc = 0; m_rv = 0; m_rill = 0; m_err = 0;
    m_cc_id = 0; m_rid = 0; m_rres = '0;
    for (int s = 0; s < MaxSeq; s++) begin
      m_done[s] = 0; m_ill[s] = 0; m_res[s] = '0;
    end
  endtask

  function automatic bit modelReady();
    int occ;
    occ = m_iss - m_ret + (m_rv ? 1 : 0);
    return core_ready_i && (occ != Depth) && !(flush_i || m_flush_prev);
  endfunction

  task automatic checkOutput();
    int occ;
    bit full, blk;
    occ  = m_iss - m_ret + (m_rv ? 1 : 0);
    full = (occ == Depth);
    blk  = flush_i || m_flush_prev;
    checkVal("issue_ready", 64'(issue_ready_o), 64'(core_ready_i && !full && !blk));
    checkVal("core_valid", 64'(core_valid_o), 64'(issue_valid_i && !full && !blk));
    checkVal("issue_id", 64'(issue_id_o), 64'(m_iss % Depth));
    checkVal("core_id", 64'(core_id_o), 64'(m_iss % Depth));
    checkVal("core_insn", 64'(core_insn_o), 64'(issue_insn_i));
    checkVal("core_ctx", 64'(core_ctx_o), 64'(issue_ctx_i));
    checkVal("outstanding", 64'(outstanding_o), 64'(occ));
    checkVal("flush_o", 64'(flush_o), 64'(m_flush_o));
    checkVal("can_commit", 64'(can_commit_o), 64'(m_cc));
    if (m_cc) checkVal("can_commit_id", 64'(can_commit_id_o), 64'(m_cc_id));
    checkVal("retire_valid", 64'(retire_valid_o), 64'(m_rv));
    if (m_rv) begin
      checkVal("retire_id", 64'(retire_id_o), 64'(m_rid));
      checkVal("retire_illegal", 64'(retire_illegal_o), 64'(m_rill));
      checkVal("retire_result", retire_result_o, m_rres);
    end
    checkVal("protocol_err", 64'(protocol_err_o), 64'(m_err));
  endtask

  task automatic stepModel();
    int  old_cmt, old_iss;
    bit  hs, found;
    hs      = issue_valid_i && modelReady();
    old_cmt = m_cmt;
    old_iss = m_iss;
    if (core_done_i) begin
      found = 0;
      for (int s = m_ret; s < old_cmt; s++) begin
        if ((s % Depth) == int'(core_done_id_i)) begin
          m_done[s] = 1; m_ill[s] = core_illegal_i; m_res[s] = core_result_i; found = 1;
        end
      end
      if (!found) m_err = 1;
    end
    m_cc = 0;
    if (commit_req_i) begin
      if (old_cmt < old_iss) begin
        m_cc = 1; m_cc_id = old_cmt % Depth; m_cmt++;
      end else begin
        m_err = 1;
      end
    end
    m_rv = 0;
    if (m_ret < old_cmt && m_done[m_ret]) begin
      m_rv = 1; m_rid = m_ret % Depth; m_rill = m_ill[m_ret]; m_rres = m_res[m_ret]; m_ret++;
    end
    if (hs) begin
      m_done[old_iss] = 0; m_iss++;
    end
    if (flush_i) m_iss = m_cmt;
    m_flush_o    = flush_i;
    m_flush_prev = flush_i;
  endtask

  task automatic applyStimulus(input bit iv, input bit cr, input bit creq, input bit fl,
                               input bit dn, input logic [IdWidth-1:0] did,
                               input bit ill, input logic [63:0] res);
    issue_valid_i  = iv;
    core_ready_i   = cr;
    commit_req_i   = creq;
    flush_i        = fl;
    core_done_i    = dn;
    core_done_id_i = did;
    core_illegal_i = ill;
    core_result_i  = res;
    issue_insn_i   = $urandom;
    issue_ctx_i    = $urandom;
    #1;
    last_ready = issue_ready_o;
    last_id    = issue_id_o;
    checkOutput();
    stepModel();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 1, 0, 0, 0, '0, 0, '0);
  endtask

  task automatic issueOne();
    applyStimulus(1, 1, 0, 0, 0, '0, 0, '0);
  endtask

  task automatic resetDut();
    rst_i = 1'b1;
    issue_valid_i = 0; core_ready_i = 0; commit_req_i = 0; flush_i = 0; core_done_i = 0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    modelReset();
  endtask

  initial begin
    bit iv, cr, creq, fl, dn, ill;
    logic [IdWidth-1:0] did;
    logic [63:0] res;
    int cand[$];

    modelReset();
    resetDut();
    checkVal("reset_outstanding", 64'(outstanding_o), 64'd0);
    checkVal("reset_flush_o", 64'(flush_o), 64'd0);
    checkVal("reset_can_commit", 64'(can_commit_o), 64'd0);
    checkVal("reset_retire_valid", 64'(retire_valid_o), 64'd0);
    checkVal("reset_protocol_err", 64'(protocol_err_o), 64'd0);

    // Three back-to-back issues receive IDs 0,1,2.
    for (int i = 0; i < 3; i++) begin
      issueOne();
      checkVal("t1_id", 64'(last_id), 64'(i));
    end
    checkVal("t1_outstanding", 64'(outstanding_o), 64'd3);
    checkVal("t1_no_commit", 64'(can_commit_o), 64'd0);
    checkVal("t1_no_retire", 64'(retire_valid_o), 64'd0);

    // Commit grants one cycle after each request; out-of-order done retires in order.
    resetDut();
    issueOne(); issueOne();
    applyStimulus(0, 1, 1, 0, 0, '0, 0, '0);
    checkVal("t2_cc0", 64'(can_commit_o), 64'd1);
    checkVal("t2_cc0_id", 64'(can_commit_id_o), 64'd0);
    applyStimulus(0, 1, 1, 0, 0, '0, 0, '0);
    checkVal("t2_cc1", 64'(can_commit_o), 64'd1);
    checkVal("t2_cc1_id", 64'(can_commit_id_o), 64'd1);
    applyStimulus(0, 1, 0, 0, 1, 3'd1, 0, 64'h11);
    checkVal("t2_no_retire_yet", 64'(retire_valid_o), 64'd0);
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 0, 64'h22);
    checkVal("t2_ret0", 64'(retire_valid_o), 64'd1);
    checkVal("t2_ret0_id", 64'(retire_id_o), 64'd0);
    checkVal("t2_ret0_res", retire_result_o, 64'h22);
    idle();
    checkVal("t2_ret1", 64'(retire_valid_o), 64'd1);
    checkVal("t2_ret1_id", 64'(retire_id_o), 64'd1);
    checkVal("t2_ret1_res", retire_result_o, 64'h11);

    // Fill all eight slots, then free one and see issue resume with ID 0 two cycles after done.
    resetDut();
    for (int i = 0; i < 8; i++) issueOne();
    issueOne();
    checkVal("t3_full_ready", 64'(last_ready), 64'd0);
    checkVal("t3_full_occ", 64'(outstanding_o), 64'd8);
    applyStimulus(1, 1, 1, 0, 0, '0, 0, '0);
    applyStimulus(1, 1, 0, 0, 1, 3'd0, 0, 64'h5);
    checkVal("t3_done_cycle_ready", 64'(last_ready), 64'd0);
    issueOne();
    checkVal("t3_plus1_ready", 64'(last_ready), 64'd0);
    issueOne();
    checkVal("t3_plus2_ready", 64'(last_ready), 64'd1);
    checkVal("t3_wrap_id", 64'(last_id), 64'd0);
    checkVal("t3_wrap_occ", 64'(outstanding_o), 64'd8);

    // Flush truncates to the commit point and blocks issue for two cycles.
    resetDut();
    for (int i = 0; i < 4; i++) issueOne();
    applyStimulus(0, 1, 1, 0, 0, '0, 0, '0);
    applyStimulus(1, 1, 0, 1, 0, '0, 0, '0);
    checkVal("t4_flush_ready", 64'(last_ready), 64'd0);
    checkVal("t4_flush_o", 64'(flush_o), 64'd1);
    checkVal("t4_flush_occ", 64'(outstanding_o), 64'd1);
    issueOne();
    checkVal("t4_block2_ready", 64'(last_ready), 64'd0);
    checkVal("t4_flush_o_gone", 64'(flush_o), 64'd0);
    issueOne();
    checkVal("t4_resume_ready", 64'(last_ready), 64'd1);
    checkVal("t4_resume_id", 64'(last_id), 64'd1);

    // Protocol errors are sticky and never cause a retire.
    resetDut();
    issueOne(); issueOne();
    applyStimulus(0, 1, 0, 0, 1, 3'd1, 0, 64'h9);
    checkVal("t5_err_done", 64'(protocol_err_o), 64'd1);
    checkVal("t5_no_retire", 64'(retire_valid_o), 64'd0);
    idle(); idle();
    checkVal("t5_err_sticky", 64'(protocol_err_o), 64'd1);
    resetDut();
    applyStimulus(0, 1, 1, 0, 0, '0, 0, '0);
    checkVal("t5_err_commit", 64'(protocol_err_o), 64'd1);
    checkVal("t5_no_cc", 64'(can_commit_o), 64'd0);

    // Illegal flag and result travel to the retire port.
    resetDut();
    issueOne();
    applyStimulus(0, 1, 1, 0, 0, '0, 0, '0);
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 1, 64'hDEAD);
    checkVal("t6_ret", 64'(retire_valid_o), 64'd1);
    checkVal("t6_illegal", 64'(retire_illegal_o), 64'd1);
    checkVal("t6_result", retire_result_o, 64'hDEAD);

    // Randomized traffic against the model.
    resetDut();
    for (int c = 0; c < 3000; c++) begin
      if (($urandom % 400) == 0) begin
        resetDut();
      end
      iv   = ($urandom % 4) != 0;
      cr   = ($urandom % 4) != 0;
      creq = (m_cmt < m_iss) ? (($urandom % 2) == 1) : (($urandom % 200) == 0);
      fl   = ($urandom % 30) == 0;
      ill  = ($urandom % 4) == 0;
      res  = {$urandom, $urandom};
      dn   = 0;
      did  = '0;
      cand.delete();
      for (int s = m_ret; s < m_cmt; s++) if (!m_done[s]) cand.push_back(s);
      if (cand.size() > 0 && ($urandom % 2) == 1) begin
        dn  = 1;
        did = IdWidth'(cand[$urandom % cand.size()] % Depth);
      end else if (($urandom % 150) == 0) begin
        dn  = 1;
        did = IdWidth'($urandom);
      end
      applyStimulus(iv, cr, creq, fl, dn, did, ill, res);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
